ipg_gap_extract: RTL and testbench
==================================

Name: ipg_gap_extract

Overview:
- Receive-side inter-packet-gap (IPG) side-channel extractor in the 10G PHY RX path.
- Sits between the 64b/66b RX interface (descrambled, block-locked output) and the BASE-R decoder.
- Finds custom IPG-carrier control blocks, pulls out their payload bits and length, and rewrites each one as a standard idle block. The decoder downstream never sees the custom block type.

Parameters:
- DATA_WIDTH, 64, block payload width; only 64 is supported.
- HDR_WIDTH, 2, sync header width; only 2 is supported.
- IPG_BLOCK_TYPE, 8'h5A, block-type byte that marks an IPG carrier block. This value is not a legal 10GBASE-R block type.
- MAX_LEN, 48, maximum number of payload bits per carrier block.

Ports:
- clk  in  1  RX clock. Rising edge only.
- rst  in  1  Reset, asynchronous, active-low. Asserted when 0.
- encoded_rx_data  in  64  Descrambled 64b/66b block payload. Bit 0 is the first bit received; byte 0 is bits [7:0].
- encoded_rx_hdr  in  2  Sync header. 2'b01 = data block, 2'b10 = control block.
- rx_ipg_data  out  64  Extracted IPG payload, LSB-aligned, registered.
- rx_len  out  6  Number of valid bits in rx_ipg_data, registered. 0 means no payload this cycle.
- recoved_encoded_rx_data  out  64  Block payload forwarded to the decoder, combinational. It pairs with the same-cycle encoded_rx_hdr, which is not delayed.

Behaviour:
- Carrier block detection: a block is a carrier when encoded_rx_hdr == 2'b10 and encoded_rx_data[7:0] == IPG_BLOCK_TYPE.
- Carrier block layout:
  - [7:0] block type.
  - [13:8] len.
  - [15:14] reserved, transmitted as 0.
  - [63:16] payload; payload bit i = encoded_rx_data[16+i].
- Effective length L = min(len, MAX_LEN).
- Recovered data (combinational, zero latency):
  - Carrier block: output the standard idle control block 64'h0000_0000_0000_001E.
  - Every other block passes through bit-exact. This includes data blocks, other control blocks, and invalid headers 2'b00/2'b11.
  - A data block (hdr 2'b01) whose byte 0 equals IPG_BLOCK_TYPE is not a carrier and passes through unchanged.
- Extraction (registered, 1-cycle latency), updated on every clk edge:
  - Carrier block: rx_len <= L; rx_ipg_data <= {16'h0, payload with bits at positions >= L forced to 0}.
  - Non-carrier block: rx_len <= 0, rx_ipg_data <= 0.
  - Payload bits above L are always zero on the output.
- Back-to-back carrier blocks each produce their own output cycle. No accumulation or stall; there is no handshake.
- Reset:
  - When rst == 0: rx_len = 0 and rx_ipg_data = 0 immediately, independent of clk. They stay 0 while reset is held.
  - The first carrier block after release appears on the following edge.
  - recoved_encoded_rx_data stays combinational and is not affected by rst.
- Reserved bits [15:14] are ignored when IPG_RX_STRICT_EN is not defined.

Optional Feature:
- Macro: IPG_RX_STRICT_EN.
- When defined, a carrier block is malformed if len > MAX_LEN or bits [15:14] != 0.
- For a malformed carrier:
  - Recovered data = error control block: byte 0 = 8'h1E, all eight 7-bit lanes in [63:8] = 7'h1E.
  - Next cycle: rx_len = 0 and rx_ipg_data = 0.
- When not defined: len is clamped to MAX_LEN, reserved bits are ignored, and every carrier is rewritten to idle.

Test Plan:
- Standard idle block (hdr 2'b10, data 64'h...001E) and data block (hdr 2'b01, data 64'h0123456789ABCDEF):
  - recovered equals input in the same cycle.
  - rx_len = 0 and rx_ipg_data = 0 on the next edge.
- Carrier block (hdr 2'b10, data {32'h0, 16'hBEEF, 8'd16, 8'h5A}):
  - recovered = 64'h1E in the same cycle.
  - Next edge: rx_len = 16, rx_ipg_data = 64'hBEEF.
- Carrier with len = 4, payload 0xFFFF: next edge rx_len = 4, rx_ipg_data = 64'hF.
- Carrier with len = 60, payload all ones:
  - Without the macro: rx_len = 48, rx_ipg_data = 64'h0000_FFFF_FFFF_FFFF, recovered = idle.
  - With IPG_RX_STRICT_EN: rx_len = 0, recovered = error block.
- Data block (hdr 2'b01) with byte 0 = 8'h5A: passes through unchanged, rx_len = 0.
- Three back-to-back carriers with len 8, 16, 24, then rst pulled low asynchronously mid-stream:
  - Outputs show 8, 16, 24 on consecutive cycles.
  - rx_len and rx_ipg_data go to 0 immediately on reset.
  - After release, the next carrier is extracted normally.

Source files
------------

// File: rtl/ipg_gap_extract.sv
// RX-side IPG side-channel extractor: pulls payload out of IPG carrier control blocks
// and rewrites them as idle. Optional strict checking enabled with IPG_RX_STRICT_EN.
module ipg_gap_extract #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned HDR_WIDTH      = 2,
    parameter logic [7:0]  IPG_BLOCK_TYPE = 8'h5A,
    parameter int unsigned MAX_LEN        = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_rx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
    output logic [DATA_WIDTH-1:0] rx_ipg_data,
    output logic [5:0]            rx_len,
    output logic [DATA_WIDTH-1:0] recoved_encoded_rx_data
);

    localparam int unsigned LEN_W = 6;
    localparam int unsigned PAY_W = DATA_WIDTH - 16;
    localparam logic [HDR_WIDTH-1:0]  HDR_CTRL   = HDR_WIDTH'(2'b10);
    localparam logic [DATA_WIDTH-1:0] IDLE_BLOCK = DATA_WIDTH'(64'h0000_0000_0000_001E);
    localparam logic [DATA_WIDTH-1:0] ERR_BLOCK  = DATA_WIDTH'({{8{7'h1E}}, 8'h1E});

    logic                  is_carrier;
    logic                  malformed;
    logic [LEN_W-1:0]      len_field;
    logic [LEN_W-1:0]      eff_len;
    logic [PAY_W-1:0]      pay_mask;
    logic [LEN_W-1:0]      rx_len_d, rx_len_q;
    logic [DATA_WIDTH-1:0] rx_ipg_data_d, rx_ipg_data_q;

    assign is_carrier = (encoded_rx_hdr == HDR_CTRL) && (encoded_rx_data[7:0] == IPG_BLOCK_TYPE);
    assign len_field  = encoded_rx_data[13:8];

`ifdef IPG_RX_STRICT_EN
    assign malformed = (len_field > LEN_W'(MAX_LEN)) || (encoded_rx_data[15:14] != 2'b00);
`else
    assign malformed = 1'b0;
`endif

    // Lengths beyond MAX_LEN are clamped; mask keeps only the low eff_len payload bits.
    always_comb begin
        eff_len  = (len_field > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_field;
        pay_mask = ~({PAY_W{1'b1}} << eff_len);
    end

    always_comb begin
        rx_len_d                = '0;
        rx_ipg_data_d           = '0;
        recoved_encoded_rx_data = encoded_rx_data;
        if (is_carrier) begin
            if (malformed) begin
                recoved_encoded_rx_data = ERR_BLOCK;
            end else begin
                recoved_encoded_rx_data = IDLE_BLOCK;
                rx_len_d                = eff_len;
                rx_ipg_data_d           = {16'h0, encoded_rx_data[DATA_WIDTH-1:16] & pay_mask};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_len_q      <= '0;
            rx_ipg_data_q <= '0;
        end else begin
            rx_len_q      <= rx_len_d;
            rx_ipg_data_q <= rx_ipg_data_d;
        end
    end

    assign rx_len      = rx_len_q;
    assign rx_ipg_data = rx_ipg_data_q;

endmodule

// File: tb/tb_ipg_gap_extract.sv
// Self-checking bench for ipg_gap_extract: directed cases plus randomized blocks
// checked against a behavioural model.
module tb_ipg_gap_extract;

`ifdef IPG_RX_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [63:0] encoded_rx_data;
    logic [1:0]  encoded_rx_hdr;
    logic [63:0] rx_ipg_data;
    logic [5:0]  rx_len;
    logic [63:0] recoved_encoded_rx_data;

    int unsigned n_vec;
    int unsigned n_err;

    ipg_gap_extract dut (
        .clk                     (clk),
        .rst                     (rst),
        .encoded_rx_data         (encoded_rx_data),
        .encoded_rx_hdr          (encoded_rx_hdr),
        .rx_ipg_data             (rx_ipg_data),
        .rx_len                  (rx_len),
        .recoved_encoded_rx_data (recoved_encoded_rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] err_block();
        logic [63:0] e;
        e = 64'h1E;
        for (int k = 0; k < 8; k++) e[8 + 7*k +: 7] = 7'h1E;
        return e;
    endfunction

    // Reference model straight from the block-format rules.
    task automatic model(input logic [1:0] h, input logic [63:0] d,
                         output logic [63:0] rec, output logic [63:0] ipg, output logic [5:0] len);
        int unsigned lf, l;
        bit carrier, bad;
        carrier = (h == 2'b10) && (d[7:0] == 8'h5A);
        lf      = int'(d[13:8]);
        bad     = STRICT && (lf > 48 || d[15:14] != 2'b00);
        rec = d; ipg = 64'h0; len = 6'd0;
        if (carrier && bad) begin
            rec = err_block();
        end else if (carrier) begin
            l   = (lf < 48) ? lf : 48;
            rec = 64'h1E;
            len = 6'(l);
            ipg = (d >> 16) & ((64'd1 << l) - 64'd1);
        end
    endtask

    task automatic apply(input string tag, input logic [1:0] h, input logic [63:0] d,
                         input logic [63:0] e_rec, input logic [5:0] e_len, input logic [63:0] e_ipg);
        @(negedge clk);
        encoded_rx_hdr  = h;
        encoded_rx_data = d;
        #1;
        chk({tag, "_rec"}, recoved_encoded_rx_data, e_rec);
        @(posedge clk);
        #1;
        chk({tag, "_len"}, 64'(rx_len), 64'(e_len));
        chk({tag, "_ipg"}, rx_ipg_data, e_ipg);
    endtask

    task automatic apply_model(input string tag, input logic [1:0] h, input logic [63:0] d);
        logic [63:0] r, p;
        logic [5:0]  l;
        model(h, d, r, p, l);
        apply(tag, h, d, r, l, p);
    endtask

    function automatic logic [63:0] carrier(input logic [47:0] pay, input logic [5:0] len);
        return {pay, 2'b00, len, 8'h5A};
    endfunction

    initial begin
        logic [63:0] d;
        logic [1:0]  h;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        encoded_rx_hdr  = 2'b10;
        encoded_rx_data = 64'h1E;
        #1 rst = 1'b0;
        #1;
        chk("reset_len", 64'(rx_len), 64'h0);
        chk("reset_ipg", rx_ipg_data, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        apply("idle", 2'b10, 64'h1E, 64'h1E, 6'd0, 64'h0);
        apply("data", 2'b01, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 6'd0, 64'h0);
        apply("beef", 2'b10, {32'h0, 16'hBEEF, 8'd16, 8'h5A}, 64'h1E, 6'd16, 64'hBEEF);
        apply("len4", 2'b10, carrier(48'hFFFF, 6'd4), 64'h1E, 6'd4, 64'hF);
        if (STRICT)
            apply("len60", 2'b10, carrier(48'hFFFF_FFFF_FFFF, 6'd60), err_block(), 6'd0, 64'h0);
        else
            apply("len60", 2'b10, carrier(48'hFFFF_FFFF_FFFF, 6'd60), 64'h1E, 6'd48, 64'h0000_FFFF_FFFF_FFFF);
        apply("data5a", 2'b01, 64'h1122334455667F5A, 64'h1122334455667F5A, 6'd0, 64'h0);
        apply("hdr00", 2'b00, carrier(48'h1234, 6'd8), carrier(48'h1234, 6'd8), 6'd0, 64'h0);
        apply("len48", 2'b10, carrier(48'hFFFF_FFFF_FFFF, 6'd48), 64'h1E, 6'd48, 64'h0000_FFFF_FFFF_FFFF);
        apply("len0", 2'b10, carrier(48'hABCD, 6'd0), 64'h1E, 6'd0, 64'h0);

        // Back-to-back carriers, then async reset mid-stream.
        apply("b2b8",  2'b10, carrier(48'hA5A5_A5A5_A5A5, 6'd8),  64'h1E, 6'd8,  64'hA5);
        apply("b2b16", 2'b10, carrier(48'hA5A5_A5A5_A5A5, 6'd16), 64'h1E, 6'd16, 64'hA5A5);
        apply("b2b24", 2'b10, carrier(48'hA5A5_A5A5_A5A5, 6'd24), 64'h1E, 6'd24, 64'hA5A5A5);
        #2 rst = 1'b0;
        #1;
        chk("arst_len", 64'(rx_len), 64'h0);
        chk("arst_ipg", rx_ipg_data, 64'h0);
        chk("arst_rec", recoved_encoded_rx_data, 64'h1E);
        @(posedge clk);
        #1;
        chk("hold_len", 64'(rx_len), 64'h0);
        chk("hold_ipg", rx_ipg_data, 64'h0);
        @(negedge clk) rst = 1'b1;
        apply("post_rst", 2'b10, carrier(48'h0000_0000_C3C3, 6'd12), 64'h1E, 6'd12, 64'h3C3);

        for (int i = 0; i < 400; i++) begin
            h = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) h = 2'b10;
            d = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) d[7:0] = 8'h5A;
            if ($urandom_range(0, 1) == 0) d[15:14] = 2'b00;
            apply_model("rand", h, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
